sudoku_grid_loader: RTL
=======================

Name: sudoku_grid_loader

Overview:
- Upstream feeder for the Scanner stage.
- Accepts a stream of 81 puzzle digits in raster order (row 0..8, col 0..8 within each row) over a valid/ready handshake.
- Converts each digit to a 9-bit one-hot candidate mask.
- Writes each mask into a box-organised grid that drives Scanner's i_Grid directly, then presents the complete grid with a valid flag until the consumer acknowledges it.

Parameters:
CELL_W, 9, candidate mask width; only 9 is supported; elaboration error otherwise.
EMPTY_MASK, 9'h000, mask written for an empty cell (digit 0).

Ports:
i_Clk  in  1  clock.
i_Rst_n  in  1  asynchronous, active-low reset.
i_Start  in  1  single-cycle pulse: clear grid and begin a load.
i_Valid  in  1  i_Digit valid this cycle.
i_Digit  in  4 (8 with GRID_LOADER_ASCII_EN)  digit code.
o_Ready  out  1  loader accepts a digit this cycle.
o_Grid  out  [8:0] x [2:0][2:0][8:0]  grid indexed [box_row][box_col][cell].
o_Grid_Valid  out  1  complete grid held on o_Grid.
i_Ack  in  1  consumer has taken the grid.
o_Count  out  7  cells accepted in the current load, 0..81.
o_Err  out  1  sticky: an illegal digit was seen this load.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - All o_Grid cells = 0.
  - o_Ready = 0, o_Grid_Valid = 0, o_Count = 0, o_Err = 0.
  - State = IDLE.
- States: IDLE, LOAD, DONE.
- IDLE:
  - o_Ready = 0; i_Valid ignored.
  - i_Start -> LOAD on the next edge; every cell set to EMPTY_MASK; o_Count, o_Err, row and col counters cleared.
- LOAD:
  - o_Ready = 1.
  - A digit is accepted on an edge where i_Valid && o_Ready.
  - The accepted cell is written on that edge and is visible on o_Grid in the next cycle.
- Cell mapping:
  - Row and column counters; no divider.
  - box_row = row/3, box_col = col/3, cell = 3*(row%3) + (col%3).
  - Implemented as two mod-3 sub-counters per axis.
  - col wraps 8 -> 0 and increments row.
- Digit encoding:
  - 0 -> EMPTY_MASK.
  - d in 1..9 -> 9'b1 << (d-1).
  - 10..15 -> cell written as EMPTY_MASK, o_Err set (sticky until the next i_Start), position still advances.
- o_Count increments on each accept.
- 81st accept: o_Ready drops the next cycle; state -> DONE; o_Grid_Valid = 1 from that cycle.
- DONE:
  - o_Ready = 0; o_Grid held stable.
  - i_Ack -> IDLE on the next edge; o_Grid_Valid = 0; grid contents retained.
- i_Start in LOAD or DONE: restarts the load exactly as from IDLE (clear, counters 0, o_Err 0); takes priority over i_Valid and i_Ack in the same cycle.
- i_Ack outside DONE: ignored.
- Async reset mid-load: immediate return to reset values; the partial grid is discarded.
- No combinational path from i_Valid to o_Ready; o_Ready is a state decode only.

Optional Feature:
GRID_LOADER_ASCII_EN
- Defined:
  - i_Digit is 8 bits ASCII.
  - '1'..'9' (0x31..0x39) -> one-hot.
  - '0' (0x30) and '.' (0x2E) -> EMPTY_MASK.
  - Any other byte sets o_Err and writes EMPTY_MASK.
- Undefined: 4-bit binary encoding as above.

Test Plan:
- Reset, pulse i_Start, stream the sequence 1..9 repeated 9 times with i_Valid held high -> after 81 accepts:
  - grid[0][0][0] = 9'h001, grid[0][0][1] = 9'h002, grid[0][1][0] = 9'h008, grid[1][0][0] = 9'h001;
  - o_Count = 81, o_Grid_Valid = 1, o_Ready = 0.
- Stream 81 zeros with i_Valid toggling every other cycle -> exactly 81 accepts, all cells = 9'h000, o_Err = 0.
- Digit 12 at position 40 (row 4, col 4) -> grid[1][1][4] = 0, o_Err = 1 through DONE, o_Err = 0 after the next i_Start.
- i_Start after 30 accepts -> o_Count = 0 next cycle, all cells EMPTY_MASK, a full 81-digit load then completes normally.
- i_Rst_n low mid-load at accept 50 -> all outputs at reset values within the same cycle; a subsequent i_Start and full load succeeds.
- In DONE, hold i_Valid = 1 for 10 cycles -> grid unchanged, o_Count stays 81; i_Ack -> o_Grid_Valid = 0 next cycle, grid retained.

Source files
------------

// File: rtl/sudoku_grid_loader.sv
// Streams 81 raster-order digits into a box-organised one-hot candidate grid.
// Optional build macro GRID_LOADER_ASCII_EN selects 8-bit ASCII digit input.
module sudoku_grid_loader #(
    parameter int                CELL_W     = 9,
    parameter logic [CELL_W-1:0] EMPTY_MASK = '0
) (
    input  logic                                i_Clk,
    input  logic                                i_Rst_n,
    input  logic                                i_Start,
    input  logic                                i_Valid,
`ifdef GRID_LOADER_ASCII_EN
    input  logic [7:0]                          i_Digit,
`else
    input  logic [3:0]                          i_Digit,
`endif
    output logic                                o_Ready,
    output logic [2:0][2:0][8:0][CELL_W-1:0]    o_Grid,
    output logic                                o_Grid_Valid,
    input  logic                                i_Ack,
    output logic [6:0]                          o_Count,
    output logic                                o_Err
);

    if (CELL_W != 9) begin : g_bad_cell_w
        $error("sudoku_grid_loader: CELL_W must be 9");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DONE
    } state_t;

    localparam logic [CELL_W-1:0] ONE_MASK = {{(CELL_W-1){1'b0}}, 1'b1};

    state_t            r_state;
    state_t            w_state_next;
    logic [1:0]        r_row_sub;
    logic [1:0]        r_row_box;
    logic [1:0]        r_col_sub;
    logic [1:0]        r_col_box;
    logic [6:0]        r_count;
    logic              r_err;
    logic              w_accept;
    logic [3:0]        w_cell;
    logic [CELL_W-1:0] w_mask;
    logic              w_illegal;

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (i_Start) begin
            w_state_next = S_LOAD;
        end else begin
            case (r_state)
                S_LOAD:  if (i_Valid && r_count == 7'd80) w_state_next = S_DONE;
                S_DONE:  if (i_Ack) w_state_next = S_IDLE;
                default: w_state_next = r_state;
            endcase
        end
    end

    // A restart pulse wins over a digit arriving in the same cycle.
    assign w_accept = (r_state == S_LOAD) && i_Valid && !i_Start;

    always_comb begin
        w_mask    = EMPTY_MASK;
        w_illegal = 1'b0;
`ifdef GRID_LOADER_ASCII_EN
        if (i_Digit >= 8'h31 && i_Digit <= 8'h39) begin
            w_mask = ONE_MASK << (i_Digit - 8'h31);
        end else if (i_Digit != 8'h30 && i_Digit != 8'h2E) begin
            w_illegal = 1'b1;
        end
`else
        if (i_Digit >= 4'd1 && i_Digit <= 4'd9) begin
            w_mask = ONE_MASK << (i_Digit - 4'd1);
        end else if (i_Digit != 4'd0) begin
            w_illegal = 1'b1;
        end
`endif
    end

    // Cell within a box is 3*row_sub + col_sub, built from shifts and adds.
    assign w_cell = 4'({r_row_sub, 1'b0}) + 4'(r_row_sub) + 4'(r_col_sub);

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_row_sub <= 2'd0;
            r_row_box <= 2'd0;
            r_col_sub <= 2'd0;
            r_col_box <= 2'd0;
            r_count   <= 7'd0;
            r_err     <= 1'b0;
        end else if (i_Start) begin
            r_row_sub <= 2'd0;
            r_row_box <= 2'd0;
            r_col_sub <= 2'd0;
            r_col_box <= 2'd0;
            r_count   <= 7'd0;
            r_err     <= 1'b0;
        end else if (w_accept) begin
            r_count <= r_count + 7'd1;
            r_err   <= r_err | w_illegal;
            if (r_col_sub != 2'd2) begin
                r_col_sub <= r_col_sub + 2'd1;
            end else begin
                r_col_sub <= 2'd0;
                if (r_col_box != 2'd2) begin
                    r_col_box <= r_col_box + 2'd1;
                end else begin
                    r_col_box <= 2'd0;
                    if (r_row_sub != 2'd2) begin
                        r_row_sub <= r_row_sub + 2'd1;
                    end else begin
                        r_row_sub <= 2'd0;
                        r_row_box <= (r_row_box == 2'd2) ? 2'd0 : r_row_box + 2'd1;
                    end
                end
            end
        end
    end

    genvar gi, gj, gk;
    for (gi = 0; gi < 3; gi++) begin : g_box_row
        for (gj = 0; gj < 3; gj++) begin : g_box_col
            for (gk = 0; gk < 9; gk++) begin : g_cell
                logic [CELL_W-1:0] r_cell;
                always_ff @(posedge i_Clk or negedge i_Rst_n) begin
                    if (!i_Rst_n) begin
                        r_cell <= '0;
                    end else if (i_Start) begin
                        r_cell <= EMPTY_MASK;
                    end else if (w_accept && r_row_box == 2'(gi) &&
                                 r_col_box == 2'(gj) && w_cell == 4'(gk)) begin
                        r_cell <= w_mask;
                    end
                end
                assign o_Grid[gi][gj][gk] = r_cell;
            end
        end
    end

    assign o_Ready      = (r_state == S_LOAD);
    assign o_Grid_Valid = (r_state == S_DONE);
    assign o_Count      = r_count;
    assign o_Err        = r_err;

endmodule
